// File: rtl/serial_word_feeder_pkg.sv
// Shared definitions for the serial word feeder: FSM state encoding and default word width.
package serial_word_feeder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } feeder_state_e;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: accepts words over valid/ready and emits one bit per clock,
// with a one-word pending buffer so consecutive words stream without a bubble.
module serial_word_feeder
    import serial_word_feeder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             din,
    output logic             bit_valid,
    output logic             word_start,
    output logic             word_end,
    output logic             busy
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    feeder_state_e    state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [WIDTH-1:0] pend_reg, pend_next;
    logic             pend_full_reg, pend_full_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic             accept;

    assign load_ready = rst & ~pend_full_reg;
    assign accept     = load_valid & load_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            shreg_reg     <= '0;
            pend_reg      <= '0;
            pend_full_reg <= 1'b0;
            bit_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            pend_reg      <= pend_next;
            pend_full_reg <= pend_full_next;
            bit_cnt_reg   <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shreg_next     = shreg_reg;
        pend_next      = pend_reg;
        pend_full_next = pend_full_reg;
        bit_cnt_next   = bit_cnt_reg;

        if (abort) begin
            // Shifter is zeroed so din reads 0 while idle without any output gating.
            state_next     = ST_IDLE;
            shreg_next     = '0;
            pend_full_next = 1'b0;
            bit_cnt_next   = '0;
        end else if (state_reg == ST_SHIFT) begin
            if (bit_cnt_reg == LAST_CNT) begin
                bit_cnt_next = '0;
                if (pend_full_reg) begin
                    shreg_next     = pend_reg;
                    pend_full_next = 1'b0;
                end else if (accept) begin
                    shreg_next = load_data;
                end else begin
                    state_next = ST_IDLE;
                    shreg_next = '0;
                end
            end else begin
                if (MSB_FIRST)
                    shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
                else
                    shreg_next = {1'b0, shreg_reg[WIDTH-1:1]};
                bit_cnt_next = bit_cnt_reg + 1'b1;
                if (accept) begin
                    pend_next      = load_data;
                    pend_full_next = 1'b1;
                end
            end
        end else if (accept) begin
            state_next   = ST_SHIFT;
            shreg_next   = load_data;
            bit_cnt_next = '0;
        end
    end

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign din = shreg_reg[WIDTH-1];
        end else begin : g_lsb_first
            assign din = shreg_reg[0];
        end
    endgenerate

    assign bit_valid  = (state_reg == ST_SHIFT);
    assign word_start = bit_valid & (bit_cnt_reg == '0);
    assign word_end   = bit_valid & (bit_cnt_reg == LAST_CNT);
    assign busy       = bit_valid | pend_full_reg;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench: accepted words are expanded into an expected bit queue; a monitor pops
// one entry per valid output bit and requires the stream to stay gap-free while bits are owed.
module tb_serial_word_feeder;

    localparam int W = 32;

    typedef struct {
        logic b;
        logic s;
        logic e;
    } exp_bit_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        abort = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = '0;
    logic        din, bit_valid, word_start, word_end, busy;

    logic        load_valid8 = 1'b0;
    logic        load_ready8;
    logic [7:0]  load_data8 = '0;
    logic        din8, bit_valid8, word_start8, word_end8, busy8;
    logic        abort8 = 1'b0;

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    exp_bit_t    q[$];

    always #5 clk = ~clk;

    serial_word_feeder #(.WIDTH(32), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .abort(abort), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .din(din), .bit_valid(bit_valid), .word_start(word_start),
        .word_end(word_end), .busy(busy)
    );

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk(clk), .rst(rst), .abort(abort8), .load_valid(load_valid8), .load_ready(load_ready8),
        .load_data(load_data8), .din(din8), .bit_valid(bit_valid8), .word_start(word_start8),
        .word_end(word_end8), .busy(busy8)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [31:0] d);
        for (int i = 0; i < W; i++) begin
            exp_bit_t e;
            e.b = d[i];
            e.s = (i == 0);
            e.e = (i == W - 1);
            q.push_back(e);
        end
    endtask

    // One cycle of stimulus; the model accepts a word only while fewer than a full word of bits is owed.
    task automatic step(input logic r, input logic v, input logic [31:0] d, input logic a);
        bit acc;
        @(negedge clk);
        #1;
        rst = r;
        abort = a;
        load_valid = v;
        load_data = d;
        #1;
        chk("load_ready", load_ready, r && (q.size() < W));
        acc = v && r && !a && (q.size() < W);
        if (acc) push_word(d);
        $display("step rst=%0b valid=%0b abort=%0b data=%08h accepted=%0b owed=%0d", r, v, a, d, acc, q.size());
        if (a || !r) begin
            @(posedge clk);
            #1;
            q.delete();
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_bit_t e;
        if (mon_en) begin
            chk("bit_valid", bit_valid, q.size() != 0);
            if (bit_valid && q.size() != 0) begin
                e = q.pop_front();
                chk("din", din, e.b);
                chk("word_start", word_start, e.s);
                chk("word_end", word_end, e.e);
                chk("busy", busy, 1'b1);
            end else if (!bit_valid) begin
                chk("din_idle", din, 1'b0);
                chk("word_start_idle", word_start, 1'b0);
                chk("word_end_idle", word_end, 1'b0);
                chk("busy_idle", busy, 1'b0);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp8;
        exp8 = 8'b1010_0101;

        // Reset held for two edges
        step(1'b0, 1'b0, 32'h0, 1'b0);
        mon_en = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b0);

        // Single word, then back-to-back offers during it
        step(1'b1, 1'b1, 32'h6AA36155, 1'b0);
        repeat (34) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        step(1'b1, 1'b1, 32'h12345678, 1'b0);
        repeat (10) step(1'b1, 1'b1, 32'hCAFEF00D, 1'b0);
        repeat (100) step(1'b1, 1'b0, 32'h0, 1'b0);

        // Offer exactly on the last-bit edge with pending empty
        step(1'b1, 1'b1, 32'h0F0F00FF, 1'b0);
        repeat (31) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h80000001, 1'b0);
        repeat (34) step(1'b1, 1'b0, 32'h0, 1'b0);

        // Abort at bit 10 with pending full, offering a word on the same edge
        step(1'b1, 1'b1, 32'hAAAA5555, 1'b0);
        step(1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
        repeat (9) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h77777777, 1'b1);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);

        // Reset for one edge at bit 20, then a fresh word
        step(1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
        repeat (20) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h5A5A5A5A, 1'b0);
        step(1'b1, 1'b1, 32'h00000001, 1'b0);
        repeat (34) step(1'b1, 1'b0, 32'h0, 1'b0);

        // Randomized traffic with occasional abort and reset
        repeat (1500) begin
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), $urandom,
                 ($urandom_range(0, 199) == 0));
        end
        repeat (80) step(1'b1, 1'b0, 32'h0, 1'b0);

        // Narrow MSB-first instance
        @(negedge clk);
        #1;
        load_valid8 = 1'b1;
        load_data8 = 8'hA5;
        #1;
        chk("load_ready8", load_ready8, 1'b1);
        @(posedge clk);
        #1;
        load_valid8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bit_valid8", bit_valid8, 1'b1);
            chk("din8", din8, exp8[7 - i]);
            chk("word_start8", word_start8, i == 0);
            chk("word_end8", word_end8, i == 7);
            $display("msb8 bit=%0d din=%0b", i, din8);
        end
        @(negedge clk);
        chk("bit_valid8_after", bit_valid8, 1'b0);
        chk("din8_after", din8, 1'b0);
        chk("busy8_after", busy8, 1'b0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
